fir_sample_sequencer: RTL and testbench
=======================================

# fir_sample_sequencer

Upstream controller for the `sram_8blk` sample store in the FIR datapath. Accepts one input sample per valid/ready handshake and writes it into a circular delay line in SRAM. It then reads back the newest `N_TAPS` samples, newest first, and streams them with a tap index to the downstream MAC stage. It owns every SRAM port signal (`A`, `D`, `WEN`, `CEN`) and consumes `Q`.

## Interface
- `DW`, 20: sample / SRAM data width.
- `AW`, 11: SRAM address width.
- `BUF_LEN`, 2048: circular buffer length in words; `N_TAPS` ≤ `BUF_LEN` ≤ 2^`AW`.
- `N_TAPS`, 16: taps read per sample, ≥ 2.
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: input sample valid.
- `in_data` in `DW`: input sample.
- `in_ready` out 1: block accepts a sample; high only in IDLE.
- `sram_a` out `AW`: SRAM address, registered.
- `sram_d` out `DW`: SRAM write data, registered.
- `sram_wen` out 1: SRAM write enable, active-low, registered.
- `sram_cen` out 1: SRAM chip enable, active-low, registered.
- `sram_q` in `DW`: SRAM read data; valid the cycle after a read is presented.
- `tap_valid` out 1: tap output valid. No backpressure; the MAC always accepts.
- `tap_data` out `DW`: tap sample.
- `tap_idx` out $clog2(`N_TAPS`): tap index k, where 0 = newest sample.
- `tap_last` out 1: high with k = `N_TAPS`-1.

## Operation
- **FSM states:** IDLE, WRITE, READ, DRAIN.
- **IDLE:** `in_ready`=1. On `in_valid`&`in_ready`, latch `in_data` and go to WRITE.
- **WRITE (1 cycle):** present `sram_cen`=0, `sram_wen`=0, `sram_a`=`wr_ptr`, `sram_d`=latched sample. Go to READ with `k`=0.
- **READ (`N_TAPS` cycles):**
  - Present `sram_cen`=0, `sram_wen`=1, `sram_a`=(`wr_ptr` − k) mod `BUF_LEN`.
  - The subtraction wraps at `BUF_LEN`, not 2^`AW`. For example, with `wr_ptr`=1 and k=3, `sram_a`=`BUF_LEN`−2.
  - Increment k each cycle. After k=`N_TAPS`-1, go to DRAIN.
- **DRAIN (1 cycle):**
  - Capture the final `sram_q`.
  - `wr_ptr` ← `wr_ptr`+1, wrapping `BUF_LEN`-1 → 0.
  - Go to IDLE.
- **SRAM idle state:** outside WRITE and READ, `sram_cen`=1 and `sram_wen`=1. `sram_a` and `sram_d` hold their last values.
- **Tap output:** `sram_q` is registered into `tap_data` one cycle after each read presentation. `tap_valid`, `tap_idx` and `tap_last` are aligned with `tap_data`.
- **Read-after-write:** tap 0 is the sample just written, read back from SRAM. No internal bypass.
- **Reset:**
  - All outputs go to: `in_ready`=0, `sram_cen`=1, `sram_wen`=1, `sram_a`=0, `sram_d`=0, `tap_valid`=0, `tap_data`=0, `tap_idx`=0, `tap_last`=0.
  - Internal state goes to: `wr_ptr`=0, fill count 0, state IDLE.
  - `in_ready` rises the cycle after `rst` deasserts.
- **Reset mid-operation:** the in-flight sequence is abandoned. No further `tap_valid`, no `tap_last`, no `wr_ptr` advance.
- **`in_valid` outside IDLE:** ignored. The sample is not consumed.

## Timing
- Let C be the cycle in which the handshake completes.
- SRAM write is presented in cycle C+1.
- Read for tap k is presented in cycle C+2+k.
- Tap k appears on `tap_data` in cycle C+3+k.
- `tap_last` is in cycle C+2+`N_TAPS`, which is also the DRAIN cycle.
- `in_ready` is high again in cycle C+3+`N_TAPS`. The earliest next handshake is in that cycle.
- Throughput: one sample per `N_TAPS`+3 cycles.
- `tap_valid` pulses are contiguous, exactly `N_TAPS` per accepted sample.

## Configuration
- Macro: `FIR_ZERO_FILL_EN`.
- **Defined:**
  - A fill counter saturates at `N_TAPS`. It counts accepted samples, including the current one.
  - For tap k ≥ fill count, no SRAM read is issued (`sram_cen`=1 that cycle). `tap_data`=0, but `tap_valid`, `tap_idx` and `tap_last` keep their normal timing.
  - Reset clears the counter.
- **Undefined:** every tap reads SRAM and `tap_data`=`sram_q` unconditionally, including uninitialised words.

## Test plan
Bench parameters: `BUF_LEN`=8, `N_TAPS`=4, with a `sram_8blk` behavioural model.

1. **Reset:** hold `rst` 3 cycles with `in_valid`=1.
   - During reset, all outputs are at their reset values and no handshake occurs.
   - `in_ready`=1 the cycle after release.
2. **Single sample:** send sample 5 into an SRAM preloaded with zeros.
   - Write at addr 0 in C+1.
   - Reads at 0, 7, 6, 5.
   - Taps (k, data) = (0,5), (1,0), (2,0), (3,0); `tap_last` in C+6; `in_ready` back in C+7.
3. **Wrap-around:** send samples 1..10 back-to-back.
   - The 9th sample writes addr 0.
   - The 10th sample's taps read addrs 1, 0, 7, 6 and return data 10, 9, 8, 7.
4. **`FIR_ZERO_FILL_EN`:** preload SRAM with 0xFFFFF and send samples 3, then 4.
   - Second sequence returns 4, 3, 0, 0, with `sram_cen`=1 for k=2,3.
   - Without the macro, the same sequence returns 4, 3, 0xFFFFF, 0xFFFFF.
5. **Reset mid-read:** assert `rst` in C+4.
   - No `tap_last`.
   - Next sample writes addr 0.
6. **`in_valid` held high outside IDLE:** hold `in_valid`=1 continuously with changing data.
   - Only the values present in handshake cycles C, C+7, C+14, … are written.

Source files
------------

// File: rtl/fir_sample_sequencer.sv
// Circular-buffer SRAM sequencer for the FIR datapath: stores each accepted sample, then streams the newest N_TAPS back newest-first.
// Optional FIR_ZERO_FILL_EN: taps older than the number of samples accepted since reset read as zero without touching SRAM.
module fir_sample_sequencer #(
  parameter int DW      = 20,
  parameter int AW      = 11,
  parameter int BUF_LEN = 2048,
  parameter int N_TAPS  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [DW-1:0]             in_data,
  output logic                      in_ready,
  output logic [AW-1:0]             sram_a,
  output logic [DW-1:0]             sram_d,
  output logic                      sram_wen,
  output logic                      sram_cen,
  input  logic [DW-1:0]             sram_q,
  output logic                      tap_valid,
  output logic [DW-1:0]             tap_data,
  output logic [$clog2(N_TAPS)-1:0] tap_idx,
  output logic                      tap_last
);

  localparam int KW = $clog2(N_TAPS);
  localparam logic [KW-1:0] K_LAST = KW'(N_TAPS - 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t        state, next_state;
  logic [KW-1:0] k, next_k;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] tap_hold;
  logic [DW-1:0] tap_live;
  logic          next_skip;

  always_comb begin
    next_state = state;
    next_k     = k;
    case (state)
      IDLE:  if (in_valid && in_ready) next_state = WRITE;
      WRITE: begin
        next_state = READ;
        next_k     = '0;
      end
      READ: begin
        if (k == K_LAST) next_state = DRAIN;
        else             next_k = k + KW'(1);
      end
      DRAIN:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Delay-line address wraps at BUF_LEN; the true result is below BUF_LEN so mod-2^AW arithmetic is exact.
  always_comb begin
    rd_addr = wr_ptr - AW'(next_k);
    if (wr_ptr < AW'(next_k)) rd_addr = rd_addr + AW'(BUF_LEN);
  end

  // SRAM pins are loaded from the next state so they are presented in the cycle the FSM occupies that state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      k         <= '0;
      wr_ptr    <= '0;
      in_ready  <= 1'b0;
      sram_a    <= '0;
      sram_d    <= '0;
      sram_wen  <= 1'b1;
      sram_cen  <= 1'b1;
      tap_valid <= 1'b0;
      tap_idx   <= '0;
      tap_last  <= 1'b0;
      tap_hold  <= '0;
    end else begin
      state    <= next_state;
      k        <= next_k;
      in_ready <= (next_state == IDLE);
      sram_cen <= 1'b1;
      sram_wen <= 1'b1;
      case (next_state)
        WRITE: begin
          sram_cen <= 1'b0;
          sram_wen <= 1'b0;
          sram_a   <= wr_ptr;
          sram_d   <= in_data;
        end
        READ: begin
          sram_cen <= next_skip;
          sram_a   <= rd_addr;
        end
        default: ;
      endcase
      tap_valid <= (state == READ);
      tap_idx   <= k;
      tap_last  <= (state == READ) && (k == K_LAST);
      if (state == DRAIN) begin
        tap_hold <= tap_live;
        wr_ptr   <= (wr_ptr == AW'(BUF_LEN - 1)) ? '0 : wr_ptr + AW'(1);
      end
    end
  end

`ifdef FIR_ZERO_FILL_EN
  localparam int FW = $clog2(N_TAPS + 1);

  logic [FW-1:0] fill;
  logic          tap_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      fill     <= '0;
      tap_zero <= 1'b0;
    end else begin
      if (state == IDLE && in_valid && in_ready && fill != FW'(N_TAPS))
        fill <= fill + FW'(1);
      tap_zero <= (state == READ) && (32'(fill) <= 32'(k));
    end
  end

  assign next_skip = (32'(fill) <= 32'(next_k));
  assign tap_live  = tap_zero ? '0 : sram_q;
`else
  assign next_skip = 1'b0;
  assign tap_live  = sram_q;
`endif

  // sram_q is already the SRAM output register, so it is forwarded while a tap is valid and the last tap is held otherwise.
  assign tap_data = tap_valid ? tap_live : tap_hold;

endmodule

// File: tb/tb_fir_sample_sequencer.sv
// Self-checking bench for fir_sample_sequencer with a behavioural SRAM and a delay-line reference model.
// Works with or without FIR_ZERO_FILL_EN defined.
module tb_fir_sample_sequencer;

  localparam int DW      = 20;
  localparam int AW      = 4;
  localparam int BUF_LEN = 8;
  localparam int N_TAPS  = 4;
  localparam int KW      = $clog2(N_TAPS);

`ifdef FIR_ZERO_FILL_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_d;
  logic          sram_wen;
  logic          sram_cen;
  logic [DW-1:0] sram_q;
  logic          tap_valid;
  logic [DW-1:0] tap_data;
  logic [KW-1:0] tap_idx;
  logic          tap_last;

  logic          preload_en = 1'b0;
  logic [DW-1:0] preload_val = '0;
  logic [DW-1:0] sram_mem [0:(1<<AW)-1];

  int            n_checks = 0;
  int            n_fail   = 0;

  // Reference model state: write pointer, fill count and what should sit at each buffer address.
  int            mwp   = 0;
  int            mfill = 0;
  logic [DW-1:0] model_mem [0:BUF_LEN-1];

  fir_sample_sequencer #(
    .DW(DW), .AW(AW), .BUF_LEN(BUF_LEN), .N_TAPS(N_TAPS)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .sram_a(sram_a), .sram_d(sram_d), .sram_wen(sram_wen), .sram_cen(sram_cen), .sram_q(sram_q),
    .tap_valid(tap_valid), .tap_data(tap_data), .tap_idx(tap_idx), .tap_last(tap_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (preload_en) begin
      for (int i = 0; i < (1 << AW); i++) sram_mem[i] <= preload_val;
    end else if (!sram_cen) begin
      if (!sram_wen) sram_mem[sram_a] <= sram_d;
      else           sram_q <= sram_mem[sram_a];
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int wrap(input int v);
    return ((v % BUF_LEN) + BUF_LEN) % BUF_LEN;
  endfunction

  function automatic logic [DW-1:0] exp_tap(input int wa, input int j);
    if (ZF && j >= mfill) return '0;
    return model_mem[wrap(wa - j)];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ready_wait", 32'(in_ready), 32'd1);
  endtask

  task automatic preload(input logic [DW-1:0] v);
    preload_val = v;
    preload_en  = 1'b1;
    @(posedge clk);
    #1 preload_en = 1'b0;
    for (int i = 0; i < BUF_LEN; i++) model_mem[i] = v;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst      = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mwp   = 0;
    mfill = 0;
    wait_ready();
  endtask

  // Call at a negedge where in_ready is high; that cycle becomes the handshake cycle C.
  task automatic applyStimulus(input logic [DW-1:0] d, input bit hold);
    int  wa;
    wa = mwp;
    if (mfill < N_TAPS) mfill++;
    model_mem[wa] = d;
    in_valid = 1'b1;
    in_data  = d;
    for (int cyc = 1; cyc <= N_TAPS + 3; cyc++) begin
      @(posedge clk);
      #1 in_data = DW'($urandom);
      if (!hold) in_valid = 1'b0;
      @(negedge clk);
      checkOutput("in_ready", 32'(in_ready), 32'(cyc == N_TAPS + 3));
      if (cyc == 1) begin
        checkOutput("wr_cen", 32'(sram_cen), 32'd0);
        checkOutput("wr_wen", 32'(sram_wen), 32'd0);
        checkOutput("wr_addr", 32'(sram_a), 32'(wa));
        checkOutput("wr_data", 32'(sram_d), 32'(d));
      end else if (cyc <= N_TAPS + 1) begin
        int  kk;
        bit  skip;
        kk   = cyc - 2;
        skip = ZF && (kk >= mfill);
        checkOutput("rd_cen", 32'(sram_cen), 32'(skip));
        checkOutput("rd_wen", 32'(sram_wen), 32'd1);
        if (!skip) checkOutput("rd_addr", 32'(sram_a), 32'(wrap(wa - kk)));
      end else begin
        checkOutput("idle_cen", 32'(sram_cen), 32'd1);
        checkOutput("idle_wen", 32'(sram_wen), 32'd1);
      end
      if (cyc >= 3 && cyc <= N_TAPS + 2) begin
        int j;
        j = cyc - 3;
        checkOutput("tap_valid", 32'(tap_valid), 32'd1);
        checkOutput("tap_idx", 32'(tap_idx), 32'(j));
        checkOutput("tap_last", 32'(tap_last), 32'(j == N_TAPS - 1));
        checkOutput("tap_data", 32'(tap_data), 32'(exp_tap(wa, j)));
      end else begin
        checkOutput("tap_valid_off", 32'(tap_valid), 32'd0);
        checkOutput("tap_last_off", 32'(tap_last), 32'd0);
      end
    end
    mwp = wrap(mwp + 1);
  endtask

  initial begin
    logic [DW-1:0] d;
    int            gap;

    // Reset held three cycles with in_valid asserted.
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = DW'($urandom);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
      checkOutput("rst_cen", 32'(sram_cen), 32'd1);
      checkOutput("rst_wen", 32'(sram_wen), 32'd1);
      checkOutput("rst_a", 32'(sram_a), 32'd0);
      checkOutput("rst_d", 32'(sram_d), 32'd0);
      checkOutput("rst_tap_valid", 32'(tap_valid), 32'd0);
      checkOutput("rst_tap_data", 32'(tap_data), 32'd0);
      checkOutput("rst_tap_idx", 32'(tap_idx), 32'd0);
      checkOutput("rst_tap_last", 32'(tap_last), 32'd0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_ready", 32'(in_ready), 32'd1);
    checkOutput("post_rst_no_write", 32'(sram_cen), 32'd1);
    $display("[TB] reset phase done");

    // Single sample into zeroed SRAM.
    preload('0);
    wait_ready();
    applyStimulus(DW'(5), 1'b0);
    $display("[TB] single sample done");

    // Ten back-to-back samples to wrap the buffer.
    do_reset();
    for (int i = 1; i <= 10; i++) applyStimulus(DW'(i), 1'b0);
    $display("[TB] wrap-around done");

    // Stale all-ones contents: zero-fill hides them, default build reads them.
    do_reset();
    preload(DW'(20'hFFFFF));
    wait_ready();
    applyStimulus(DW'(3), 1'b0);
    applyStimulus(DW'(4), 1'b0);
    $display("[TB] fill behaviour done");

    // Reset during the read phase abandons the sequence.
    wait_ready();
    d = DW'($urandom);
    in_valid = 1'b1;
    in_data  = d;
    model_mem[mwp] = d;
    repeat (4) begin
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    mwp   = 0;
    mfill = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("abort_tap_valid", 32'(tap_valid), 32'd0);
      checkOutput("abort_tap_last", 32'(tap_last), 32'd0);
      checkOutput("abort_cen", 32'(sram_cen), 32'd1);
      checkOutput("abort_in_ready", 32'(in_ready), 32'(i != 0));
    end
    applyStimulus(DW'($urandom), 1'b0);
    $display("[TB] mid-read reset done");

    // in_valid held high with data changing every cycle.
    for (int i = 0; i < 5; i++) applyStimulus(DW'($urandom), 1'b1);
    in_valid = 1'b0;
    $display("[TB] held in_valid done");

    // Random samples with random idle gaps.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(DW'($urandom), 1'b0);
      gap = int'($urandom_range(0, 3));
      repeat (gap) @(negedge clk);
    end
    $display("[TB] random phase done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
